// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding, default width and counter sizing.
package riscv_muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    // Counter must be able to hold WIDTH itself, hence one extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic f3_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM.
    function automatic logic f3_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if
    import riscv_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start_i;
    logic [2:0]       funct3_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit_sign_fixup.sv
// Final stage of the multiply/divide unit: restores operand signs on the
// magnitude result, substitutes the architected special-case values and
// selects the word the op returns.
module muldiv_sign_fixup
    import riscv_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]         funct3,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   op_a,
    input  logic               neg_q,
    input  logic               neg_r,
    input  logic               div_zero,
    input  logic               ovf,
    output logic [WIDTH-1:0]   result
);
    localparam logic [WIDTH-1:0] MIN_SIGNED = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Negate the magnitudes where needed, then pick the half/word for the op.
    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        result = '0;
        case (funct3)
            F3_MUL:                        result = prod[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:               result = div_zero ? '1 : (ovf ? MIN_SIGNED : quo);
            F3_REM, F3_REMU:               result = div_zero ? op_a : (ovf ? '0 : rem);
            default:                       result = '0;
        endcase
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies finish as soon as
// the remaining multiplier bits are all zero.
module muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic           clk,
    input logic           rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_SIGNED = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      counter;
    logic [2:0]         funct3_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic               ovf;
    logic               busy;
    logic               load;
    logic               step;
    logic               accept;
    logic               early_out;
    logic [WIDTH-1:0]   fixed_result;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;

    // Launch-time decode of the incoming operands.
    logic             is_div_in;
    logic             sign_a_in;
    logic             sign_b_in;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic             zero_in;
    logic             ovf_in;

    assign is_div_in = bus.funct3_i[2];
    assign sign_a_in = f3_signed_a(bus.funct3_i) && bus.op_a_i[WIDTH-1];
    assign sign_b_in = f3_signed_b(bus.funct3_i) && bus.op_b_i[WIDTH-1];
    assign mag_a_in  = sign_a_in ? -bus.op_a_i : bus.op_a_i;
    assign mag_b_in  = sign_b_in ? -bus.op_b_i : bus.op_b_i;
    assign zero_in   = is_div_in && (bus.op_b_i == '0);
    assign ovf_in    = ((bus.funct3_i == F3_DIV) || (bus.funct3_i == F3_REM)) &&
                       (bus.op_a_i == MIN_SIGNED) && (bus.op_b_i == '1);
    assign accept    = (state == IDLE) && bus.start_i && !bus.flush_i;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = !funct3_q[2] && (mplier[WIDTH-1:1] == '0);
`else
    assign early_out = 1'b0;
`endif

    // One iteration of shift-add (multiply) and restoring shift-subtract (divide).
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_acc_next;

    assign mul_acc_next = acc + (mplier[0] ? mcand_sh : '0);
    assign div_shift    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, mcand_sh[WIDTH-1:0]};
    assign div_acc_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                          : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: special cases skip CALC; flush aborts from any busy state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start_i && !bus.flush_i)
                      state_next = (zero_in || ovf_in) ? DONE : CALC;
            CALC: if (bus.flush_i)
                      state_next = IDLE;
                  else if ((counter == CW'(1)) || early_out)
                      state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: stall request, iteration enable and result load.
    always_comb begin
        busy = (state != IDLE);
        step = (state == CALC);
        load = (state == DONE) && !bus.flush_i;
    end

    // Datapath: latch operands on launch, iterate while in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter  <= '0;
            funct3_q <= '0;
            op_a_q   <= '0;
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            counter  <= (zero_in || ovf_in) ? '0 : CW'(WIDTH);
            funct3_q <= bus.funct3_i;
            op_a_q   <= bus.op_a_i;
            acc      <= is_div_in ? {{WIDTH{1'b0}}, mag_a_in} : '0;
            mcand_sh <= {{WIDTH{1'b0}}, is_div_in ? mag_b_in : mag_a_in};
            mplier   <= is_div_in ? '0 : mag_b_in;
            neg_q    <= sign_a_in ^ sign_b_in;
            neg_r    <= sign_a_in;
            div_zero <= zero_in;
            ovf      <= ovf_in;
        end else if (step) begin
            counter <= counter - CW'(1);
            mplier  <= mplier >> 1;
            if (funct3_q[2]) begin
                acc <= div_acc_next;
            end else begin
                acc      <= mul_acc_next;
                mcand_sh <= mcand_sh << 1;
            end
        end
    end

    muldiv_sign_fixup #(.WIDTH(WIDTH)) u_fixup (
        .funct3   (funct3_q),
        .acc      (acc),
        .op_a     (op_a_q),
        .neg_q    (neg_q),
        .neg_r    (neg_r),
        .div_zero (div_zero),
        .ovf      (ovf),
        .result   (fixed_result)
    );

    // Result register and one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= load;
            if (load) result_q <= fixed_result;
        end
    end

    assign bus.busy_o   = busy;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, flush, reset
// and randomized ops against a plain-arithmetic reference model.
// Honours MULDIV_EARLY_OUT_EN when computing expected multiply latency.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [31:0] MIN_S = 32'h8000_0000;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [31:0] last_result;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0] up;
        int ia, ib;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'h0, b};
        up = {32'h0, a} * {32'h0, b};
        ia = a;
        ib = b;
        r  = '0;
        case (f3)
            3'b000: begin p = sa * sb; r = p[31:0];  end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: r = up[63:32];
            3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ((a == MIN_S && b == 32'hFFFF_FFFF) ? MIN_S : 32'(ia / ib));
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: r = (b == 0) ? a : ((a == MIN_S && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from the start edge until done_o is seen.
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int bits;
        if (f3[2] && (b == 0 || ((f3 == 3'b100 || f3 == 3'b110) && a == MIN_S && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3[2]) begin
            mag  = (f3 == 3'b001 && b[31]) ? -b : b;
            bits = 0;
            while (mag != 0) begin
                bits++;
                mag = mag >> 1;
            end
            if (bits < 1) bits = 1;
            return bits + 1;
        end
`else
        mag  = a;
        bits = 0;
`endif
        return W + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output int busy_cnt, output logic [31:0] res);
        @(negedge clk);
        bus.funct3_i = f3;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done_o && lat < 200) begin
            if (bus.busy_o) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.result_o;
    endtask

    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int lat, busy_cnt, e;
        logic [31:0] res, exp_res;
        applyStimulus(f3, a, b, lat, busy_cnt, res);
        e       = exp_lat(f3, a, b);
        exp_res = ref_result(f3, a, b);
        checkOutput({tag, " result"}, res, exp_res);
        checkOutput({tag, " latency"}, 32'(lat), 32'(e));
        checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'(e));
        checkOutput({tag, " busy at done"}, 32'(bus.busy_o), 32'h0);
        @(posedge clk);
        #1;
        checkOutput({tag, " done pulse width"}, 32'(bus.done_o), 32'h0);
        last_result = exp_res;
    endtask

    // Directed sequence followed by randomized ops.
    initial begin
        int done_seen;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int sel, lat;

        vectors      = 0;
        miscompares  = 0;
        last_result  = '0;
        rst_n        = 1'b0;
        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.funct3_i = '0;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(bus.busy_o), 32'h0);
        checkOutput("reset done", 32'(bus.done_o), 32'h0);
        checkOutput("reset result", bus.result_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD);
        runOp("MULH min*min",    3'b001, MIN_S,          MIN_S);
        runOp("MULHU max*max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        runOp("MULHSU -1*2",     3'b010, 32'hFFFF_FFFF,  32'd2);
        runOp("DIV -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2);
        runOp("REM -7/2",        3'b110, 32'hFFFF_FFF9,  32'd2);
        runOp("DIVU 100/7",      3'b101, 32'd100,        32'd7);
        runOp("REMU 100/7",      3'b111, 32'd100,        32'd7);
        runOp("DIVU 5/0",        3'b101, 32'd5,          32'd0);
        runOp("REM 5/0",         3'b110, 32'd5,          32'd0);
        runOp("DIV ovf",         3'b100, MIN_S,          32'hFFFF_FFFF);
        runOp("REM ovf",         3'b110, MIN_S,          32'hFFFF_FFFF);
        runOp("MUL 9*1",         3'b000, 32'd9,          32'd1);
        runOp("MULH 3*-5",       3'b001, 32'd3,          32'hFFFF_FFFB);

        // Flush mid-divide with an extra start during the op.
        runOp("MUL prior",       3'b000, 32'h1234,       32'h0101);
        @(negedge clk);
        bus.funct3_i = 3'b100; bus.op_a_i = 32'd1000; bus.op_b_i = 32'd7; bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.funct3_i = 3'b000; bus.op_a_i = 32'd3; bus.op_b_i = 32'd3; bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        checkOutput("flush busy mid-op", 32'(bus.busy_o), 32'h1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        checkOutput("flush busy drop", 32'(bus.busy_o), 32'h0);
        done_seen = 0;
        repeat (40) begin
            if (bus.done_o) done_seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("flush no done", 32'(done_seen), 32'h0);
        checkOutput("flush result held", bus.result_o, last_result);

        // Start while busy must not displace the running op.
        @(negedge clk);
        bus.funct3_i = 3'b011; bus.op_a_i = 32'hDEAD_BEEF; bus.op_b_i = 32'h8000_0001; bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.funct3_i = 3'b101; bus.op_a_i = 32'd50; bus.op_b_i = 32'd0; bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat = 5;
        while (!bus.done_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("ignored start latency", 32'(lat), 32'(exp_lat(3'b011, 32'hDEAD_BEEF, 32'h8000_0001)));
        checkOutput("ignored start result", bus.result_o, ref_result(3'b011, 32'hDEAD_BEEF, 32'h8000_0001));
        last_result = bus.result_o;
        @(posedge clk);
        #1;

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        bus.funct3_i = 3'b000; bus.op_a_i = 32'd5; bus.op_b_i = 32'd5; bus.start_i = 1'b1; bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        checkOutput("start+flush idle busy", 32'(bus.busy_o), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("start+flush idle done", 32'(bus.done_o), 32'h0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.funct3_i = 3'b000; bus.op_a_i = 32'h1234; bus.op_b_i = 32'h5678; bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(bus.busy_o), 32'h0);
        checkOutput("async reset done", 32'(bus.done_o), 32'h0);
        checkOutput("async reset result", bus.result_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("post-reset DIV", 3'b100, 32'hFFFF_FC18, 32'd33);

        // Randomized ops with occasional special and short-multiplier cases.
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'h0;
            if (sel == 1) begin ra = MIN_S; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(0, 15));
            if (sel == 3) ra = 32'($urandom_range(0, 255));
            runOp("random", rf3, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
